// File: rtl/tour_pkg.sv
// Shared constants and types for the knight-tour command sequencer:
// command opcodes, compass headings, response bytes and FSM states.
package tour_pkg;

    localparam logic [3:0] OP_MOVE     = 4'h2;
    localparam logic [3:0] OP_MOVE_FAN = 4'h3;

    localparam logic [7:0] HDG_NORTH = 8'h00;
    localparam logic [7:0] HDG_WEST  = 8'h3F;
    localparam logic [7:0] HDG_SOUTH = 8'h7F;
    localparam logic [7:0] HDG_EAST  = 8'hBF;

    localparam logic [7:0] RESP_BUSY = 8'hA5;
    localparam logic [7:0] RESP_DONE = 8'h5A;

    localparam logic [4:0] LAST_INDX = 5'd23;

    typedef enum logic [2:0] {
        IDLE,
        VERT,
        WAIT_V,
        HORZ,
        WAIT_H
    } state_t;

    // Command word layout: opcode[15:12], heading[11:4], squares[3:0].
    function automatic logic [15:0] make_cmd(input logic [3:0] op,
                                             input logic [7:0] hdg,
                                             input logic [3:0] sq);
        return {op, hdg, sq};
    endfunction

endpackage

// File: rtl/knight_move_decode.sv
// Combinational decode of a one-hot knight move into its vertical leg
// (plain move) and horizontal leg (move + fanfare) command words.
module knight_move_decode
    import tour_pkg::*;
(
    input  logic [7:0]  move,
    output logic [15:0] vert_cmd,
    output logic [15:0] horz_cmd,
    output logic        one_hot
);

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        vert_cmd = make_cmd(OP_MOVE, HDG_NORTH, 4'd0);
        horz_cmd = make_cmd(OP_MOVE_FAN, HDG_EAST, 4'd0);
        one_hot  = 1'b1;
        case (move)
            8'h01: begin
                vert_cmd = make_cmd(OP_MOVE, HDG_NORTH, 4'd2);
                horz_cmd = make_cmd(OP_MOVE_FAN, HDG_EAST, 4'd1);
            end
            8'h02: begin
                vert_cmd = make_cmd(OP_MOVE, HDG_NORTH, 4'd2);
                horz_cmd = make_cmd(OP_MOVE_FAN, HDG_WEST, 4'd1);
            end
            8'h04: begin
                vert_cmd = make_cmd(OP_MOVE, HDG_NORTH, 4'd1);
                horz_cmd = make_cmd(OP_MOVE_FAN, HDG_WEST, 4'd2);
            end
            8'h08: begin
                vert_cmd = make_cmd(OP_MOVE, HDG_SOUTH, 4'd1);
                horz_cmd = make_cmd(OP_MOVE_FAN, HDG_WEST, 4'd2);
            end
            8'h10: begin
                vert_cmd = make_cmd(OP_MOVE, HDG_SOUTH, 4'd2);
                horz_cmd = make_cmd(OP_MOVE_FAN, HDG_WEST, 4'd1);
            end
            8'h20: begin
                vert_cmd = make_cmd(OP_MOVE, HDG_SOUTH, 4'd2);
                horz_cmd = make_cmd(OP_MOVE_FAN, HDG_EAST, 4'd1);
            end
            8'h40: begin
                vert_cmd = make_cmd(OP_MOVE, HDG_SOUTH, 4'd1);
                horz_cmd = make_cmd(OP_MOVE_FAN, HDG_EAST, 4'd2);
            end
            8'h80: begin
                vert_cmd = make_cmd(OP_MOVE, HDG_NORTH, 4'd1);
                horz_cmd = make_cmd(OP_MOVE_FAN, HDG_EAST, 4'd2);
            end
            default: one_hot = 1'b0;
        endcase
    end

endmodule

// File: rtl/tour_cmd.sv
// Knight-tour command sequencer: muxes UART commands with the two-leg
// commands of each tour move. Optional abort on UART traffic: TOUR_CMD_ABORT_EN.
module tour_cmd
    import tour_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_tour,
    input  logic [7:0]  move,
    output logic [4:0]  mv_indx,
    input  logic [15:0] cmd_UART,
    input  logic        cmd_rdy_UART,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    output logic [7:0]  resp
);

    state_t      state_q, state_d;
    logic [4:0]  mv_indx_q, mv_indx_d;
    logic [15:0] vert_cmd, horz_cmd;
    logic        one_hot;
    logic        last_move;

    knight_move_decode u_decode (
        .move     (move),
        .vert_cmd (vert_cmd),
        .horz_cmd (horz_cmd),
        .one_hot  (one_hot)
    );

    assign last_move = (mv_indx_q == LAST_INDX);
    assign mv_indx   = mv_indx_q;

    always_comb begin
        state_d   = state_q;
        mv_indx_d = mv_indx_q;
        case (state_q)
            IDLE: begin
                if (start_tour) begin
                    state_d   = VERT;
                    mv_indx_d = 5'd0;
                end
            end
            VERT: begin
                // A corrupt move from the solver ends the tour without issuing a command.
                if (!one_hot) begin
                    state_d   = IDLE;
                    mv_indx_d = 5'd0;
                end else if (clr_cmd_rdy) begin
                    state_d = WAIT_V;
                end
            end
            WAIT_V: begin
                if (send_resp) state_d = HORZ;
            end
            HORZ: begin
                if (clr_cmd_rdy) state_d = WAIT_H;
            end
            WAIT_H: begin
                if (send_resp) begin
                    if (last_move) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = VERT;
                        mv_indx_d = mv_indx_q + 5'd1;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                mv_indx_d = 5'd0;
            end
        endcase
`ifdef TOUR_CMD_ABORT_EN
        // UART traffic aborts the tour; the leg already handed over stays in flight.
        if (state_q != IDLE && cmd_rdy_UART) begin
            state_d   = IDLE;
            mv_indx_d = 5'd0;
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mv_indx_q <= 5'd0;
        end else begin
            state_q   <= state_d;
            mv_indx_q <= mv_indx_d;
        end
    end

    // Outputs follow the state directly so the UART passthrough in IDLE has no latency.
    always_comb begin
        cmd     = cmd_UART;
        cmd_rdy = 1'b0;
        resp    = RESP_BUSY;
        case (state_q)
            IDLE: begin
                cmd_rdy = cmd_rdy_UART & ~start_tour;
                resp    = RESP_DONE;
            end
            VERT: begin
                cmd     = vert_cmd;
                cmd_rdy = one_hot;
            end
            WAIT_V: begin
                cmd = vert_cmd;
            end
            HORZ: begin
                cmd     = horz_cmd;
                cmd_rdy = 1'b1;
                resp    = last_move ? RESP_DONE : RESP_BUSY;
            end
            WAIT_H: begin
                cmd  = horz_cmd;
                resp = last_move ? RESP_DONE : RESP_BUSY;
            end
            default: begin
                cmd     = cmd_UART;
                cmd_rdy = 1'b0;
                resp    = RESP_DONE;
            end
        endcase
    end

endmodule

// File: tb/tb_tour_cmd.sv
// Self-checking bench for tour_cmd: spec vectors, randomized tours against a
// displacement-based reference model, and reset/abort/masking sequences.
module tb_tour_cmd;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_tour;
    logic [7:0]  move;
    logic [4:0]  mv_indx;
    logic [15:0] cmd_UART;
    logic        cmd_rdy_UART;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [7:0]  resp;

    int n_tests = 0;
    int n_fail  = 0;
    int n_hs    = 0;

    // Knight displacement per move bit (+y north, +x east).
    int dy_t[8] = '{2, 2, 1, -1, -2, -2, -1, 1};
    int dx_t[8] = '{1, -1, -2, -2, -1, 1, 2, 2};

    typedef struct {
        logic [7:0]  mv;
        logic [15:0] exp_v;
        logic [15:0] exp_h;
    } vec_t;

    vec_t vecs[6];

    tour_cmd dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_tour   (start_tour),
        .move         (move),
        .mv_indx      (mv_indx),
        .cmd_UART     (cmd_UART),
        .cmd_rdy_UART (cmd_rdy_UART),
        .cmd          (cmd),
        .cmd_rdy      (cmd_rdy),
        .clr_cmd_rdy  (clr_cmd_rdy),
        .send_resp    (send_resp),
        .resp         (resp)
    );

    always #10 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    function automatic int bit_of(input logic [7:0] mv);
        for (int i = 0; i < 8; i++) if (mv[i]) return i;
        return 0;
    endfunction

    // Command word from leg direction and signed distance.
    function automatic logic [15:0] model_word(input bit vertical, input int d);
        logic [3:0] op;
        logic [7:0] hdg;
        int         a;
        logic [3:0] sq;
        op  = vertical ? 4'h2 : 4'h3;
        if (vertical) hdg = (d > 0) ? 8'h00 : 8'h7F;
        else          hdg = (d > 0) ? 8'hBF : 8'h3F;
        a   = (d < 0) ? -d : d;
        sq  = a[3:0];
        return {op, hdg, sq};
    endfunction

    // Runs one knight move starting in VERT. With stop_h set it returns in WAIT_H.
    task automatic do_move(input int idx, input logic [7:0] mv,
                           input logic [15:0] exp_v, input logic [15:0] exp_h,
                           input bit stop_h);
        bit         last;
        int         w;
        logic [7:0] exp_resp_h;
        last       = (idx == 23);
        exp_resp_h = last ? 8'h5A : 8'hA5;
        move = mv;
        settle();
        check("vert_cmd", cmd, exp_v);
        check("vert_rdy", {15'd0, cmd_rdy}, 16'd1);
        check("vert_indx", {11'd0, mv_indx}, idx[15:0]);
        check("vert_resp", {8'd0, resp}, 16'h00A5);
        w = $urandom_range(0, 2);
        for (int i = 0; i < w; i++) tick();
        settle();
        check("vert_hold", cmd, exp_v);
        if (cmd_rdy) n_hs++;
        clr_cmd_rdy = 1'b1;
        tick();
        clr_cmd_rdy = 1'b0;
        settle();
        check("wait_v_rdy", {15'd0, cmd_rdy}, 16'd0);
        check("wait_v_resp", {8'd0, resp}, 16'h00A5);
        start_tour = 1'b1;
        tick();
        start_tour = 1'b0;
        settle();
        check("ignored_start_indx", {11'd0, mv_indx}, idx[15:0]);
        check("ignored_start_rdy", {15'd0, cmd_rdy}, 16'd0);
        send_resp = 1'b1;
        tick();
        send_resp = 1'b0;
        settle();
        check("horz_cmd", cmd, exp_h);
        check("horz_rdy", {15'd0, cmd_rdy}, 16'd1);
        check("horz_resp", {8'd0, resp}, {8'd0, exp_resp_h});
        if (cmd_rdy) n_hs++;
        clr_cmd_rdy = 1'b1;
        tick();
        clr_cmd_rdy = 1'b0;
        settle();
        check("wait_h_rdy", {15'd0, cmd_rdy}, 16'd0);
        check("wait_h_resp", {8'd0, resp}, {8'd0, exp_resp_h});
        if (!stop_h) begin
            send_resp = 1'b1;
            tick();
            send_resp = 1'b0;
            settle();
            if (!last) begin
                check("next_indx", {11'd0, mv_indx}, 16'(idx + 1));
            end else begin
                check("end_indx", {11'd0, mv_indx}, 16'd23);
                check("end_resp", {8'd0, resp}, 16'h005A);
            end
        end
    endtask

    task automatic random_move(input int idx, input bit stop_h);
        logic [7:0] mv;
        int         b;
        mv = 8'h01 << $urandom_range(0, 7);
        b  = bit_of(mv);
        do_move(idx, mv, model_word(1'b1, dy_t[b]), model_word(1'b0, dx_t[b]), stop_h);
    endtask

    initial begin
        vecs[0] = '{mv: 8'h01, exp_v: 16'h2002, exp_h: 16'h3BF1};
        vecs[1] = '{mv: 8'h10, exp_v: 16'h27F2, exp_h: 16'h33F1};
        vecs[2] = '{mv: 8'h04, exp_v: 16'h2001, exp_h: 16'h33F2};
        vecs[3] = '{mv: 8'h02, exp_v: 16'h2002, exp_h: 16'h33F1};
        vecs[4] = '{mv: 8'h08, exp_v: 16'h27F1, exp_h: 16'h33F2};
        vecs[5] = '{mv: 8'h80, exp_v: 16'h2001, exp_h: 16'h3BF2};

        rst_n        = 1'b0;
        start_tour   = 1'b0;
        move         = 8'h00;
        cmd_UART     = 16'h0000;
        cmd_rdy_UART = 1'b0;
        clr_cmd_rdy  = 1'b0;
        send_resp    = 1'b0;
        tick();
        tick();
        check("reset_indx", {11'd0, mv_indx}, 16'd0);
        check("reset_resp", {8'd0, resp}, 16'h005A);
        rst_n = 1'b1;
        tick();

        // IDLE passthrough
        cmd_UART     = 16'h0000;
        cmd_rdy_UART = 1'b1;
        settle();
        check("idle_cmd", cmd, 16'h0000);
        check("idle_rdy", {15'd0, cmd_rdy}, 16'd1);
        check("idle_resp", {8'd0, resp}, 16'h005A);
        cmd_UART = 16'hC3A1;
        settle();
        check("idle_cmd2", cmd, 16'hC3A1);
        cmd_rdy_UART = 1'b0;
        settle();
        check("idle_rdy_low", {15'd0, cmd_rdy}, 16'd0);

        // Spec vectors: one move each, then a corrupt move aborts to IDLE.
        for (int i = 0; i < 6; i++) begin
            start_tour = 1'b1;
            tick();
            start_tour = 1'b0;
            do_move(0, vecs[i].mv, vecs[i].exp_v, vecs[i].exp_h, 1'b0);
            move = (i % 2 == 1) ? 8'h00 : 8'h03;
            settle();
            check("bad_move_rdy", {15'd0, cmd_rdy}, 16'd0);
            tick();
            settle();
            check("bad_move_indx", {11'd0, mv_indx}, 16'd0);
            check("bad_move_resp", {8'd0, resp}, 16'h005A);
            check("bad_move_idle_rdy", {15'd0, cmd_rdy}, 16'd0);
        end

        // start_tour colliding with a pending UART command
        cmd_UART     = 16'h1234;
        cmd_rdy_UART = 1'b1;
        start_tour   = 1'b1;
        settle();
        check("collide_rdy", {15'd0, cmd_rdy}, 16'd0);
        tick();
        start_tour = 1'b0;
`ifdef TOUR_CMD_ABORT_EN
        cmd_rdy_UART = 1'b0;
`endif
        // Full tour; without abort the UART command stays pending and masked.
        n_hs = 0;
        for (int idx = 0; idx < 24; idx++) random_move(idx, 1'b0);
        check("tour_handshakes", n_hs[15:0], 16'd48);
`ifndef TOUR_CMD_ABORT_EN
        check("forward_cmd", cmd, 16'h1234);
        check("forward_rdy", {15'd0, cmd_rdy}, 16'd1);
`endif
        cmd_rdy_UART = 1'b0;
        tick();

`ifdef TOUR_CMD_ABORT_EN
        // Mid-tour UART command aborts on the next clock.
        start_tour = 1'b1;
        tick();
        start_tour = 1'b0;
        random_move(0, 1'b0);
        random_move(1, 1'b0);
        cmd_UART     = 16'h5678;
        cmd_rdy_UART = 1'b1;
        settle();
        check("abort_inflight_rdy", {15'd0, cmd_rdy}, 16'd1);
        check("abort_inflight_indx", {11'd0, mv_indx}, 16'd2);
        tick();
        settle();
        check("abort_indx", {11'd0, mv_indx}, 16'd0);
        check("abort_cmd", cmd, 16'h5678);
        check("abort_rdy", {15'd0, cmd_rdy}, 16'd1);
        check("abort_resp", {8'd0, resp}, 16'h005A);
        cmd_rdy_UART = 1'b0;
        tick();
`endif

        // Asynchronous reset while in WAIT_H
        start_tour = 1'b1;
        tick();
        start_tour = 1'b0;
        random_move(0, 1'b0);
        random_move(1, 1'b0);
        random_move(2, 1'b1);
        check("pre_reset_indx", {11'd0, mv_indx}, 16'd2);
        #4;
        rst_n        = 1'b0;
        cmd_UART     = 16'hBEEF;
        cmd_rdy_UART = 1'b1;
        #1;
        check("rst_indx", {11'd0, mv_indx}, 16'd0);
        check("rst_cmd", cmd, 16'hBEEF);
        check("rst_rdy", {15'd0, cmd_rdy}, 16'd1);
        check("rst_resp", {8'd0, resp}, 16'h005A);
        tick();
        rst_n = 1'b1;
        settle();
        check("post_rst_indx", {11'd0, mv_indx}, 16'd0);
        check("post_rst_cmd", cmd, 16'hBEEF);
        cmd_rdy_UART = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
